// File: rtl/conv_result_collector_pkg.sv
// Shared types and saturation helpers for the conv result collector.
package conv_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } collect_state_t;

  localparam int CONV_DATA_W = 16;
  localparam int CONV_PIX_W  = 8;

  // Signed pixel bounds for an out_w-bit two's complement result.
  function automatic int sat_hi(input int out_w);
    return (32'sd1 <<< (out_w - 1)) - 32'sd1;
  endfunction

  function automatic int sat_lo(input int out_w);
    return -(32'sd1 <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/conv_result_collector_if.sv
// Output pixel stream: valid/ready with last-beat marker.
interface conv_result_collector_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/conv_result_collector_sat.sv
// Shift + signed saturation of a conv result to pixel width.
// Optional rectification when CONV_COLLECT_RELU_EN is defined.
module conv_sat_unit
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_DATA_W,
  parameter int OUT_W  = CONV_PIX_W,
  parameter int SHIFT  = 0
) (
  input  logic [DATA_W-1:0] din_i,
  output logic [OUT_W-1:0]  dout_o
);

`ifdef CONV_COLLECT_RELU_EN
  localparam bit RELU_C = 1'b1;
`else
  localparam bit RELU_C = 1'b0;
`endif

  localparam logic signed [DATA_W-1:0] HI_C = DATA_W'(sat_hi(OUT_W));
  localparam logic signed [DATA_W-1:0] LO_C = DATA_W'(sat_lo(OUT_W));

  logic signed [DATA_W-1:0] shifted_s;

  // Arithmetic shift, then clamp into the pixel range.
  always_comb begin
    shifted_s = $signed(din_i) >>> SHIFT;
    dout_o    = shifted_s[OUT_W-1:0];
    if (RELU_C && shifted_s[DATA_W-1]) begin
      dout_o = '0;
    end else if (shifted_s > HI_C) begin
      dout_o = HI_C[OUT_W-1:0];
    end else if (shifted_s < LO_C) begin
      dout_o = LO_C[OUT_W-1:0];
    end else begin
      dout_o = shifted_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/conv_result_collector.sv
// Collects saturated conv results in arrival order and drains them as a stream
// when the map completes. Optional ReLU: define CONV_COLLECT_RELU_EN.
module conv_result_collector
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_DATA_W,
  parameter int OUT_W  = CONV_PIX_W,
  parameter int DEPTH  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          conv_out_i,
  input  logic                       conv_done_i,
  input  logic                       conv_complete_i,
  conv_result_collector_if.master    m_if,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  collect_state_t    state_q, state_d;
  logic              done_q, complete_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [OUT_W-1:0]  mem_q [DEPTH];

  logic              done_edge_s, cmpl_edge_s, wr_en_s;
  logic [OUT_W-1:0]  sat_s;

  assign done_edge_s = conv_done_i & ~done_q;
  assign cmpl_edge_s = conv_complete_i & ~complete_q;

  conv_sat_unit #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_sat (
    .din_i  (conv_out_i),
    .dout_o (sat_s)
  );

  // Control registers and input edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      done_q     <= 1'b0;
      complete_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= conv_done_i;
      complete_q <= conv_complete_i;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Pixel storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= sat_s;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  // Next-state logic for collection and drain.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en_s    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (done_edge_s) begin
          if (count_q < DEPTH_C) begin
            wr_en_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          wr_en_s = 1'b0;
        end
        // count_d already includes a same-cycle capture.
        if (cmpl_edge_s) begin
          if (count_d != '0) begin
            state_d = DRAIN;
          end else begin
            overflow_d = 1'b0;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      DRAIN: begin
        if (done_edge_s) begin
          overflow_d = 1'b1;
        end else begin
          overflow_d = overflow_q;
        end
        if (m_if.m_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d  = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d    = COLLECT;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // Stream outputs decoded from registered state, pointer and buffer.
  always_comb begin
    if (state_q == DRAIN) begin
      m_if.m_valid = 1'b1;
      m_if.m_last  = (count_q == CNT_W'(1));
      m_if.m_data  = mem_q[rd_ptr_q];
    end else begin
      m_if.m_valid = 1'b0;
      m_if.m_last  = 1'b0;
      m_if.m_data  = '0;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench: default, DEPTH=4 and SHIFT=2 instances share the conv inputs.
module tb_conv_result_collector;

`ifdef CONV_COLLECT_RELU_EN
  localparam bit RELU_C = 1'b1;
`else
  localparam bit RELU_C = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] conv_out = 16'h0000;
  logic        conv_done = 1'b0;
  logic        conv_complete = 1'b0;
  logic        ready = 1'b0;

  logic [4:0] count0;
  logic [2:0] count4;
  logic [4:0] counts;
  logic       ovf0, ovf4, ovfs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_result_collector_if #(.OUT_W(8)) if0 ();
  conv_result_collector_if #(.OUT_W(8)) if4 ();
  conv_result_collector_if #(.OUT_W(8)) ifs ();
  assign if0.m_ready = ready;
  assign if4.m_ready = ready;
  assign ifs.m_ready = ready;

  conv_result_collector dut0 (
    .clk(clk), .rst(rst), .conv_out_i(conv_out), .conv_done_i(conv_done),
    .conv_complete_i(conv_complete), .m_if(if0), .count_o(count0), .overflow_o(ovf0));

  conv_result_collector #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .conv_out_i(conv_out), .conv_done_i(conv_done),
    .conv_complete_i(conv_complete), .m_if(if4), .count_o(count4), .overflow_o(ovf4));

  conv_result_collector #(.SHIFT(2)) duts (
    .clk(clk), .rst(rst), .conv_out_i(conv_out), .conv_done_i(conv_done),
    .conv_complete_i(conv_complete), .m_if(ifs), .count_o(counts), .overflow_o(ovfs));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    conv_out  = v;
    conv_done = 1'b1;
    tick();
    tick();
    conv_done = 1'b0;
    tick();
  endtask

  task automatic complete_pulse();
    conv_complete = 1'b1;
    tick();
    conv_complete = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b0; conv_done = 1'b0; conv_complete = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if ({if0.m_valid, if0.m_last, if0.m_data, count0, ovf0} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset: valid=%b last=%b data=%h count=%0d ovf=%b, want all 0",
               if0.m_valid, if0.m_last, if0.m_data, count0, ovf0);
    end
  endtask

  task automatic test_basic();
    logic [7:0] e [3];
    e = '{8'h05, (RELU_C ? 8'h00 : 8'hFD), 8'h7F};
    test_reset();
    push(16'd5); push(16'hFFFD); push(16'd300);
    complete_pulse();
    n_checks++;
    if (if0.m_valid !== 1'b1 || count0 !== 5'd3) begin
      n_fail++;
      $display("FAIL basic_enter_drain: valid=%b count=%0d, want 1 3", if0.m_valid, count0);
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (if0.m_valid !== 1'b1 || if0.m_data !== e[i] || if0.m_last !== (i == 2)) begin
        n_fail++;
        $display("FAIL basic_beat%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 i, if0.m_valid, if0.m_data, if0.m_last, e[i], (i == 2));
      end
      tick();
    end
    n_checks++;
    if (if0.m_valid !== 1'b0 || count0 !== 5'd0 || ovf0 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after: valid=%b count=%0d ovf=%b, want 0 0 0", if0.m_valid, count0, ovf0);
    end
    ready = 1'b0;
  endtask

  task automatic test_shift();
    test_reset();
    push(16'hFDA8);
    complete_pulse();
    n_checks++;
    if (ifs.m_valid !== 1'b1 || ifs.m_data !== (RELU_C ? 8'h00 : 8'h80) || ifs.m_last !== 1'b1) begin
      n_fail++;
      $display("FAIL shift2_sat: valid=%b data=%h last=%b, want 1 %h 1",
               ifs.m_valid, ifs.m_data, ifs.m_last, (RELU_C ? 8'h00 : 8'h80));
    end
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] e [3];
    logic       pat [5];
    int         beats;
    e = '{8'h0A, 8'h14, 8'h1E};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    beats = 0;
    test_reset();
    push(16'd10); push(16'd20); push(16'd30);
    complete_pulse();
    for (int i = 0; i < 5; i++) begin
      ready = pat[i];
      n_checks++;
      if (if0.m_valid !== 1'b1 || beats > 2 || if0.m_data !== e[beats % 3]) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: valid=%b data=%h, want 1 %h", i, if0.m_valid, if0.m_data, e[beats % 3]);
      end
      if (ready) beats++;
      tick();
    end
    ready = 1'b0;
    n_checks++;
    if (beats !== 3 || if0.m_valid !== 1'b0 || count0 !== 5'd0) begin
      n_fail++;
      $display("FAIL bp_end: beats=%0d valid=%b count=%0d, want 3 0 0", beats, if0.m_valid, count0);
    end
  endtask

  task automatic test_overflow();
    test_reset();
    for (int i = 1; i <= 6; i++) push(16'(i));
    n_checks++;
    if (count4 !== 3'd4 || ovf4 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_full: count=%0d ovf=%b, want 4 1", count4, ovf4);
    end
    complete_pulse();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (if4.m_valid !== 1'b1 || if4.m_data !== 8'(i + 1) || ovf4 !== 1'b1 || if4.m_last !== (i == 3)) begin
        n_fail++;
        $display("FAIL ovf_beat%0d: valid=%b data=%h ovf=%b last=%b, want 1 %h 1 %b",
                 i, if4.m_valid, if4.m_data, ovf4, if4.m_last, 8'(i + 1), (i == 3));
      end
      tick();
    end
    n_checks++;
    if (if4.m_valid !== 1'b0 || ovf4 !== 1'b0 || count4 !== 3'd0) begin
      n_fail++;
      $display("FAIL ovf_after: valid=%b ovf=%b count=%0d, want 0 0 0", if4.m_valid, ovf4, count4);
    end
    ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [7:0] e [3];
    e = '{8'h07, 8'h08, 8'h09};
    test_reset();
    push(16'd7); push(16'd8);
    conv_out = 16'd9; conv_done = 1'b1; conv_complete = 1'b1;
    tick();
    conv_done = 1'b0; conv_complete = 1'b0;
    n_checks++;
    if (if0.m_valid !== 1'b1 || count0 !== 5'd3) begin
      n_fail++;
      $display("FAIL simul_enter: valid=%b count=%0d, want 1 3", if0.m_valid, count0);
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (if0.m_valid !== 1'b1 || if0.m_data !== e[i] || if0.m_last !== (i == 2)) begin
        n_fail++;
        $display("FAIL simul_beat%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 i, if0.m_valid, if0.m_data, if0.m_last, e[i], (i == 2));
      end
      tick();
    end
    n_checks++;
    if (if0.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_after: valid=%b, want 0", if0.m_valid);
    end
    ready = 1'b0;
  endtask

  task automatic test_empty_complete();
    int seen;
    seen = 0;
    test_reset();
    conv_complete = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if0.m_valid !== 1'b0) seen++;
    end
    conv_complete = 1'b0;
    n_checks++;
    if (seen !== 0 || count0 !== 5'd0) begin
      n_fail++;
      $display("FAIL empty_cmpl: valid_cycles=%0d count=%0d, want 0 0", seen, count0);
    end
  endtask

  task automatic test_reset_mid_drain();
    int beats;
    beats = 0;
    test_reset();
    push(16'd1); push(16'd2); push(16'd3);
    complete_pulse();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (if0.m_valid !== 1'b0 || count0 !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_mid: valid=%b count=%0d, want 0 0", if0.m_valid, count0);
    end
    push(16'd40); push(16'd50);
    complete_pulse();
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (if0.m_valid === 1'b1) begin
        n_checks++;
        if (if0.m_data !== (beats == 0 ? 8'h28 : 8'h32)) begin
          n_fail++;
          $display("FAIL rst_map_beat%0d: data=%h, want %h", beats, if0.m_data, (beats == 0 ? 8'h28 : 8'h32));
        end
        beats++;
      end
      tick();
    end
    ready = 1'b0;
    n_checks++;
    if (beats !== 2) begin
      n_fail++;
      $display("FAIL rst_map_beats: beats=%0d, want 2", beats);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shift();
    test_backpressure();
    test_overflow();
    test_simultaneous();
    test_empty_complete();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
